instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage feeding the RV32I core's instr_in path. Holds the fetch PC and issues
//  word requests to instruction memory over a req/gnt + rvalid handshake. Buffers
//  returned words with their PCs in a small FIFO and presents them to the core on a
//  valid/ready interface. On a core redirect (taken branch/jump) it flushes the FIFO,
//  discards in-flight responses, and restarts fetching at the new target.
// PARAMETERS
//  DEPTH            4              FIFO entries (power of 2, >=2)
//  MAX_OUTSTANDING  2              max granted requests awaiting rvalid (1..DEPTH)
//  RESET_PC         32'h0000_0000  fetch address after reset (word aligned)
// PORTS
//  clk               in   1   clock
//  rst               in   1   synchronous reset, active-high
//  redirect_in       in   1   core redirect strobe
//  redirect_addr_in  in   32  new fetch target; bits [1:0] ignored
//  im_req_out        out  1   fetch request to instruction memory
//  im_addr_out       out  32  fetch address, word aligned
//  im_gnt_in         in   1   request accepted when im_req_out & im_gnt_in
//  im_rvalid_in      in   1   response valid, in request order, >=1 cycle after gnt
//  im_rdata_in       in   32  response instruction word
//  instr_valid_out   out  1   FIFO head valid
//  instr_out         out  32  FIFO head instruction; 32'h0000_0013 (NOP) when not valid
//  instr_pc_out      out  32  PC of FIFO head
//  instr_ready_in    in   1   core accepts head when instr_valid_out & instr_ready_in
//  err_out           out  1   sticky: rvalid received with no outstanding request
// BEHAVIOUR
//  Reset: im_req_out=0, im_addr_out=RESET_PC, instr_valid_out=0, instr_out=NOP,
//   instr_pc_out=0, err_out=0. FIFO, outstanding and discard counters =0, state=RUN.
//   A reset asserted mid-operation drops all in-flight state. Responses arriving after
//   reset with no outstanding request set err_out.
//  FSM: RUN  - issue requests; accept responses into FIFO.
//       FLUSH- im_req_out=0; every rvalid decrements discard_cnt and is dropped;
//              go to RUN on the cycle discard_cnt reaches 0.
//  Issue rule (RUN, no redirect): im_req_out=1 iff outstanding<MAX_OUTSTANDING and
//   fifo_count+outstanding<DEPTH. While im_req_out=1 and no gnt, im_addr_out is held.
//  On req&gnt: im_addr_out += 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), outstanding++.
//  On rvalid in RUN: push {rdata, pc of oldest outstanding}, outstanding--. The issue
//   rule makes FIFO overflow impossible.
//  Push and pop in the same cycle: both take effect; count unchanged.
//  Latency: earliest instr_valid_out is 1 cycle after the rvalid cycle (registered FIFO).
//  Redirect (takes priority over all other events in that cycle):
//   - FIFO cleared. Any pop in the same cycle is void; the core discards it.
//   - im_addr_out <= {redirect_addr_in[31:2],2'b00}; im_req_out=0 next cycle.
//   - discard_cnt <= outstanding + (req&gnt this cycle) - (rvalid this cycle).
//     The same-cycle rvalid is dropped. outstanding <= discard_cnt value.
//   - If that value is 0, stay/return RUN; otherwise go to FLUSH.
//   - A redirect during FLUSH updates the target and keeps the count; the newest
//     target wins.
//  rvalid with outstanding==0: ignored, err_out<=1, cleared only by rst.
//  Counters are sized clog2(MAX_OUTSTANDING+1) and clog2(DEPTH+1); no wrap permitted.
// TESTING
//  1 Reset then gnt=1, rvalid 1 cycle after each gnt, ready=1 -> im_addr 0,4,8..; instr_out
//    follows rdata with instr_pc_out 0,4,8; no gaps at steady state; err_out=0.
//  2 ready=0, DEPTH=4 -> after 4 words FIFO full, im_req_out=0. ready=1 for 1 cycle ->
//    one pop, exactly one new request issued.
//  3 Two requests outstanding (0x10,0x14), redirect to 0x203 -> FLUSH; both responses
//    dropped; next request addr 0x200; first instr_pc_out=0x200.
//  4 Redirect in the same cycle as gnt(0x8) and rvalid(0x4) -> rvalid(0x4) dropped,
//    gnt(0x8) counted stale and its later response dropped; fetch resumes at target.
//  5 Redirect to 0xFFFF_FFF8, gnt always -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
//  6 rvalid pulse with nothing outstanding -> err_out=1, FIFO unchanged; rst -> err_out=0,
//    im_addr_out=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RV32I fetch stage: PC, imem req/gnt/rvalid, instruction FIFO, redirect flush
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   redirect_in/_addr_in       core redirect strobe and new target (bits [1:0] ignored)
//   im_req_out, im_addr_out    word request to instruction memory
//   im_gnt_in                  request accepted when im_req_out & im_gnt_in
//   im_rvalid_in, im_rdata_in  in-order response from instruction memory
//   instr_valid_out            FIFO head valid
//   instr_out, instr_pc_out    FIFO head word (NOP when empty) and its PC (0 when empty)
//   instr_ready_in             core accepts head when instr_valid_out & instr_ready_in
//   err_out                    sticky: response arrived with nothing outstanding
module instr_fetch_unit #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_in,
    input  logic [31:0] redirect_addr_in,
    output logic        im_req_out,
    output logic [31:0] im_addr_out,
    input  logic        im_gnt_in,
    input  logic        im_rvalid_in,
    input  logic [31:0] im_rdata_in,
    output logic        instr_valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc_out,
    input  logic        instr_ready_in,
    output logic        err_out
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {RUN, FLUSH} state_t;
    state_t state, state_next;

    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] fifo_count, fifo_count_next;
    // In FLUSH this counter holds the stale responses still to be discarded
    // (the discard count); in RUN it holds live requests awaiting rvalid.
    logic [OW-1:0] outstanding, outstanding_next;

    logic        granted, rsp_ok, push, pop, req_next;
    logic [31:0] rsp_pc;

    always_comb begin
        granted = im_req_out & im_gnt_in;
        rsp_ok  = im_rvalid_in && (outstanding != '0);
        push    = rsp_ok && (state == RUN) && !redirect_in;
        pop     = instr_valid_out && instr_ready_in && !redirect_in;
        // Requests are issued at consecutive word addresses, so the oldest
        // outstanding one sits 4*outstanding bytes behind the fetch pointer.
        rsp_pc  = im_addr_out - 32'({outstanding, 2'b00});

        outstanding_next = outstanding + OW'(granted) - OW'(rsp_ok);
        fifo_count_next  = redirect_in ? '0 : (fifo_count + CW'(push) - CW'(pop));

        if (outstanding_next == '0)
            state_next = RUN;
        else if (redirect_in)
            state_next = FLUSH;
        else
            state_next = state;

        // Registered request: computed from the post-edge counters, which gives
        // the issue rule and keeps the address/request stable until granted.
        req_next = !redirect_in && (state_next == RUN)
                   && (int'(outstanding_next) < MAX_OUTSTANDING)
                   && (int'(fifo_count_next) + int'(outstanding_next) < DEPTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            im_req_out  <= 1'b0;
            im_addr_out <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            err_out     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= NOP;
                fifo_pc[i]   <= '0;
            end
        end else begin
            state       <= state_next;
            im_req_out  <= req_next;
            outstanding <= outstanding_next;
            fifo_count  <= fifo_count_next;
            if (im_rvalid_in && (outstanding == '0))
                err_out <= 1'b1;
            if (redirect_in) begin
                im_addr_out <= {redirect_addr_in[31:2], 2'b00};
                rd_ptr      <= '0;
                wr_ptr      <= '0;
            end else begin
                if (granted)
                    im_addr_out <= im_addr_out + 32'd4;
                if (push) begin
                    fifo_data[wr_ptr] <= im_rdata_in;
                    fifo_pc[wr_ptr]   <= rsp_pc;
                    wr_ptr            <= wr_ptr + AW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    assign instr_valid_out = (fifo_count != '0);
    assign instr_out       = instr_valid_out ? fifo_data[rd_ptr] : NOP;
    assign instr_pc_out    = instr_valid_out ? fifo_pc[rd_ptr] : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized bench for instr_fetch_unit against a queue-based reference model
module tb_instr_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam int          MAXO     = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_in;
    logic [31:0] redirect_addr_in;
    logic        im_req_out;
    logic [31:0] im_addr_out;
    logic        im_gnt_in;
    logic        im_rvalid_in;
    logic [31:0] im_rdata_in;
    logic        instr_valid_out;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;
    logic        instr_ready_in;
    logic        err_out;

    instr_fetch_unit #(
        .DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAXO),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .redirect_in(redirect_in),
        .redirect_addr_in(redirect_addr_in),
        .im_req_out(im_req_out),
        .im_addr_out(im_addr_out),
        .im_gnt_in(im_gnt_in),
        .im_rvalid_in(im_rvalid_in),
        .im_rdata_in(im_rdata_in),
        .instr_valid_out(instr_valid_out),
        .instr_out(instr_out),
        .instr_pc_out(instr_pc_out),
        .instr_ready_in(instr_ready_in),
        .err_out(err_out)
    );

    always #5 clk = ~clk;

    // Reference model: memory requests in flight (with a stale flag set by
    // redirects), PCs buffered for the core, and the next fetch address.
    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } req_t;

    req_t        pend[$];
    logic [31:0] fq[$];
    logic [31:0] gnt_log[$];
    logic [31:0] m_addr;
    bit          m_err, redir_last, post_reset;
    int          checks, passed, fails, n_grants;
    int          p_gnt, p_rv, p_rdy, p_redir;
    bit          f_redir, f_rv;
    logic [31:0] f_raddr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC3A5_0F96;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int          stale_n = 0;
        bit          exp_req, gnt, rv, rdy, redir, acc;
        logic [31:0] raddr;
        req_t        r;
        foreach (pend[i]) if (pend[i].stale) stale_n++;
        exp_req = !post_reset && !redir_last && (stale_n == 0) && (pend.size() < MAXO)
                  && (fq.size() + pend.size() < DEPTH);
        check("im_req_out", 32'(im_req_out), 32'(exp_req));
        if (exp_req) check("im_addr_out", im_addr_out, m_addr);
        check("instr_valid_out", 32'(instr_valid_out), 32'(fq.size() != 0));
        if (fq.size() != 0) begin
            check("instr_pc_out", instr_pc_out, fq[0]);
            check("instr_out", instr_out, mem_word(fq[0]));
        end else begin
            check("instr_out_nop", instr_out, NOP);
        end
        check("err_out", 32'(err_out), 32'(m_err));

        gnt   = ($urandom_range(99) < p_gnt);
        rv    = f_rv || ((pend.size() != 0) && ($urandom_range(99) < p_rv));
        rdy   = ($urandom_range(99) < p_rdy);
        redir = f_redir || ($urandom_range(99) < p_redir);
        if (f_redir) raddr = f_raddr;
        else if ($urandom_range(3) == 0) raddr = 32'hFFFF_FFF0 | $urandom_range(15);
        else raddr = $urandom;

        im_gnt_in        = gnt;
        im_rvalid_in     = rv;
        im_rdata_in      = (pend.size() != 0) ? mem_word(pend[0].pc) : $urandom;
        instr_ready_in   = rdy;
        redirect_in      = redir;
        redirect_addr_in = raddr;
        f_redir = 1'b0;
        f_rv    = 1'b0;

        acc = rdy && (fq.size() != 0) && !redir;
        if (acc) void'(fq.pop_front());
        if (rv) begin
            if (pend.size() == 0) m_err = 1'b1;
            else begin
                r = pend.pop_front();
                if (!r.stale && !redir) fq.push_back(r.pc);
            end
        end
        if (im_req_out && gnt) begin
            pend.push_back('{m_addr, 1'b0});
            gnt_log.push_back(im_addr_out);
            n_grants++;
            m_addr += 32'd4;
        end
        if (redir) begin
            fq.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            m_addr = {raddr[31:2], 2'b00};
        end
        redir_last = redir;
        post_reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        im_gnt_in = 1'b0; im_rvalid_in = 1'b0; instr_ready_in = 1'b0;
        redirect_in = 1'b0; redirect_addr_in = '0; im_rdata_in = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_im_req", 32'(im_req_out), 32'd0);
        check("rst_im_addr", im_addr_out, RESET_PC);
        check("rst_valid", 32'(instr_valid_out), 32'd0);
        check("rst_instr", instr_out, NOP);
        check("rst_pc", instr_pc_out, 32'd0);
        check("rst_err", 32'(err_out), 32'd0);
        rst = 1'b0;
        pend.delete();
        fq.delete();
        m_addr = RESET_PC;
        m_err = 1'b0;
        redir_last = 1'b0;
        post_reset = 1'b1;
    endtask

    initial begin
        int v, g0, k;
        checks = 0; passed = 0; fails = 0; n_grants = 0;
        f_redir = 1'b0; f_rv = 1'b0; f_raddr = '0;

        // Streaming with gnt always, one-cycle response, core always ready.
        do_reset();
        p_gnt = 100; p_rv = 100; p_rdy = 100; p_redir = 0;
        for (int i = 0; i < 8; i++) cycle();
        check("first_addr0", gnt_log[0], 32'h0);
        check("first_addr1", gnt_log[1], 32'h4);
        check("first_addr2", gnt_log[2], 32'h8);
        v = 0;
        for (int i = 0; i < 10; i++) begin
            v += int'(instr_valid_out);
            cycle();
        end
        check("steady_no_gaps", v, 10);

        // Core stalls: FIFO fills, requests stop; a single pop refills once.
        p_rdy = 0;
        for (int i = 0; i < 12; i++) cycle();
        check("full_valid", 32'(instr_valid_out), 32'd1);
        check("full_no_req", 32'(im_req_out), 32'd0);
        p_rdy = 100; cycle(); p_rdy = 0;
        g0 = n_grants;
        for (int i = 0; i < 6; i++) cycle();
        check("one_refill", n_grants - g0, 1);

        // Redirect with two requests outstanding and no responses yet.
        do_reset();
        p_gnt = 100; p_rv = 0; p_rdy = 100;
        k = 0;
        while (pend.size() < 2 && k < 10) begin cycle(); k++; end
        check("two_outstanding", pend.size(), 2);
        f_redir = 1'b1; f_raddr = 32'h0000_0203;
        cycle();
        g0 = gnt_log.size();
        p_rv = 100;
        k = 0;
        while (!instr_valid_out && k < 20) begin cycle(); k++; end
        check("flush_pc", instr_pc_out, 32'h0000_0200);
        check("flush_addr", (gnt_log.size() > g0) ? gnt_log[g0] : 32'hDEAD_BEEF, 32'h0000_0200);

        // Redirect colliding with a grant and a response in the same cycle.
        for (int i = 0; i < 6; i++) cycle();
        f_redir = 1'b1; f_raddr = 32'h0000_0402;
        cycle();
        g0 = gnt_log.size();
        k = 0;
        while (!instr_valid_out && k < 20) begin cycle(); k++; end
        check("collide_pc", instr_pc_out, 32'h0000_0400);
        check("collide_addr", (gnt_log.size() > g0) ? gnt_log[g0] : 32'hDEAD_BEEF, 32'h0000_0400);

        // Address wrap at the top of the address space.
        f_redir = 1'b1; f_raddr = 32'hFFFF_FFF9;
        cycle();
        g0 = gnt_log.size();
        k = 0;
        while (gnt_log.size() < g0 + 3 && k < 20) begin cycle(); k++; end
        check("wrap_a0", (gnt_log.size() > g0) ? gnt_log[g0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
        check("wrap_a1", (gnt_log.size() > g0 + 1) ? gnt_log[g0 + 1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("wrap_a2", (gnt_log.size() > g0 + 2) ? gnt_log[g0 + 2] : 32'hDEAD_BEEF, 32'h0000_0000);

        // Spurious response with nothing outstanding; FIFO contents preserved.
        p_gnt = 0; p_rdy = 0;
        k = 0;
        while (pend.size() != 0 && k < 20) begin cycle(); k++; end
        cycle();
        f_rv = 1'b1;
        cycle();
        cycle();
        check("err_set", 32'(err_out), 32'd1);
        do_reset();

        // Long randomized run with random redirects.
        p_gnt = 70; p_rv = 60; p_rdy = 70; p_redir = 4;
        for (int i = 0; i < 3000; i++) cycle();
        p_redir = 0; p_rv = 100; p_rdy = 100;
        for (int i = 0; i < 20; i++) cycle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
